pio_ext: RTL and testbench
==========================

PIO_EXT -- requirements
Module: pio_ext

Interface
REQ-001 Parameter DATA_W, default 32: width of output port register and bus data.
REQ-002 Parameter LED_N, default 8: number of LED outputs, driven from GPIOf0[LED_N-1:0]; LED_N <= DATA_W.
REQ-003 Parameter IN_W, default 8: number of general-purpose inputs; IN_W <= DATA_W.
REQ-004 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period; >= 2.
REQ-005 Parameter RST_VAL, default 0: GPIOf0 value after reset.
REQ-006 clk  input  1  system clock; all state updates on the falling edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 EN  input  1  write strobe, sampled on falling clk edge.
REQ-009 addr  input  2  register select.
REQ-010 PData_in  input  DATA_W  write data.
REQ-011 PData_out  output  DATA_W  read data, combinational from addr.
REQ-012 gpio_in  input  IN_W  asynchronous external inputs.
REQ-013 GPIOf0  output  DATA_W  output port register.
REQ-014 LED  output  LED_N  active-low LED drive.
REQ-015 irq  output  1  level interrupt, high while any edge flag is set.

Function
REQ-016 Register map: addr 0 OUT, addr 1 TOGGLE, addr 2 BLINK mask (LED_N bits), addr 3 EDGE flags (IN_W bits).
REQ-017 EN with addr 0: GPIOf0 <= PData_in; EN with addr 1: GPIOf0 <= GPIOf0 ^ PData_in; without EN: GPIOf0 holds.
REQ-018 EN with addr 2: blink_mask <= PData_in[LED_N-1:0].
REQ-019 EN with addr 3: write-1-to-clear; each EDGE bit i is cleared where PData_in[i] = 1.
REQ-020 Reads: addr 0/1 return GPIOf0; addr 2 returns blink_mask zero-extended; addr 3 returns EDGE zero-extended.
REQ-021 Blink prescaler: counter counts 0..BLINK_DIV-1 and wraps to 0; on wrap, phase toggles. Phase period = 2*BLINK_DIV cycles.
REQ-022 LED[i] = ~(GPIOf0[i] & (~blink_mask[i] | phase)), combinational.
REQ-023 gpio_in passes through a 2-stage synchroniser, then a rising-edge detector (sync2 high, previous low).
REQ-024 A detected edge sets EDGE[i] one falling edge after detection; flag is sticky until cleared.
REQ-025 Simultaneous W1C and new edge on the same bit: set wins, flag stays 1.
REQ-026 Latency gpio_in rising to irq high: 3 falling edges (2 sync stages, then the flag).
REQ-027 irq = |EDGE, combinational.

Reset
REQ-028 rst asserted: GPIOf0 = RST_VAL, blink_mask = 0, counter = 0, phase = 0, EDGE = 0, sync and previous-value flops = 0, immediately without waiting for clk.
REQ-029 Consequently LED = ~RST_VAL[LED_N-1:0] and irq = 0 during reset.
REQ-030 Writes and edge detection while rst is high are ignored. An input already high at reset release produces one edge after release.

Structure
REQ-031 Shared package pio_pkg holds the address constants ADDR_OUT, ADDR_TOG, ADDR_BLINK, ADDR_EDGE.
REQ-032 One sub-module, pio_sync_edge (parameter W), contains the synchroniser and the rising-edge detector and outputs a W-bit one-cycle pulse vector.

Verification
REQ-033 Reset with RST_VAL=32'h0000_00A5 -> GPIOf0=32'h0000_00A5, LED=8'h5A, irq=0, PData_out(addr 2/3)=0.
REQ-034 Write addr0 32'h0000_00F0, then addr1 32'h0000_00FF -> GPIOf0 32'h0000_00F0 then 32'h0000_000F, LED=8'hF0.
REQ-035 BLINK_DIV=4, GPIOf0=8'h01, mask=8'h01 -> LED[0] alternates every 4 cycles; LED[7:1] stay 1.
REQ-036 gpio_in[2] 0->1 -> irq high at 3rd falling edge, EDGE=8'h04; write addr3 8'h04 -> irq low next edge.
REQ-037 New edge on bit 2 in the same cycle as W1C of bit 2 -> EDGE[2] remains 1, irq remains high.
REQ-038 Assert rst mid-blink with EDGE set -> all state returns to REQ-028 values asynchronously, with no glitch writes.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared register-map constants for the PIO extension block.
package pio_pkg;

  localparam logic [1:0] ADDR_OUT   = 2'd0;
  localparam logic [1:0] ADDR_TOG   = 2'd1;
  localparam logic [1:0] ADDR_BLINK = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

endpackage

// File: rtl/pio_ext_if.sv
// Register-bus bundle between a bus master and the PIO extension block.
interface pio_ext_if #(
  parameter int unsigned DATA_W = 32
);

  logic              EN;
  logic [1:0]        addr;
  logic [DATA_W-1:0] PData_in;
  logic [DATA_W-1:0] PData_out;

  modport master (
    output EN,
    output addr,
    output PData_in,
    input  PData_out
  );

  modport slave (
    input  EN,
    input  addr,
    input  PData_in,
    output PData_out
  );

endinterface

// File: rtl/pio_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; all flops update on the falling edge.
module pio_sync_edge #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] pulse_o
);

  logic [W-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pio_ext.sv
// GPIO output port with toggle, per-LED blink masking and sticky rising-edge input flags.
module pio_ext
  import pio_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       LED_N     = 8,
  parameter int unsigned       IN_W      = 8,
  parameter int unsigned       BLINK_DIV = 25000000,
  parameter logic [DATA_W-1:0] RST_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst,
  pio_ext_if.slave          bus,
  input  logic [IN_W-1:0]   gpio_in,
  output logic [DATA_W-1:0] GPIOf0,
  output logic [LED_N-1:0]  LED,
  output logic              irq
);

  localparam int unsigned CntW = $clog2(BLINK_DIV);

  logic [DATA_W-1:0] gpio_d, gpio_q;
  logic [LED_N-1:0]  mask_d, mask_q;
  logic [IN_W-1:0]   edge_d, edge_q, edge_clr, edge_pulse;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic              phase_d, phase_q;

  pio_sync_edge #(
    .W (IN_W)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .d_i     (gpio_in),
    .pulse_o (edge_pulse)
  );

  always_comb begin
    gpio_d   = gpio_q;
    mask_d   = mask_q;
    edge_clr = '0;
    if (bus.EN) begin
      unique case (bus.addr)
        ADDR_OUT:   gpio_d   = bus.PData_in;
        ADDR_TOG:   gpio_d   = gpio_q ^ bus.PData_in;
        ADDR_BLINK: mask_d   = bus.PData_in[LED_N-1:0];
        ADDR_EDGE:  edge_clr = bus.PData_in[IN_W-1:0];
        default:    ;
      endcase
    end
    // A fresh edge overrides a simultaneous write-1-to-clear.
    edge_d = (edge_q & ~edge_clr) | edge_pulse;
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CntW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      gpio_q  <= RST_VAL;
      mask_q  <= '0;
      edge_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    bus.PData_out = '0;
    unique case (bus.addr)
      ADDR_OUT, ADDR_TOG: bus.PData_out = gpio_q;
      ADDR_BLINK:         bus.PData_out[LED_N-1:0] = mask_q;
      ADDR_EDGE:          bus.PData_out[IN_W-1:0] = edge_q;
      default:            ;
    endcase
  end

  assign GPIOf0 = gpio_q;
  assign LED    = ~(gpio_q[LED_N-1:0] & (~mask_q | {LED_N{phase_q}}));
  assign irq    = |edge_q;

endmodule

// File: tb/tb_pio_ext.sv
// Scoreboard bench for pio_ext: stimulus queues expected snapshots, a posedge monitor compares them.
module tb_pio_ext;

  logic        clk;
  logic        rst;
  logic [7:0]  gpio_in;
  logic [31:0] GPIOf0;
  logic [7:0]  LED;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  pio_ext_if #(.DATA_W(32)) bus ();

  pio_ext #(
    .DATA_W    (32),
    .LED_N     (8),
    .IN_W      (8),
    .BLINK_DIV (4),
    .RST_VAL   (32'h0000_00A5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .gpio_in (gpio_in),
    .GPIOf0  (GPIOf0),
    .LED     (LED),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [31:0] gpio;
    logic [7:0]  led;
    logic [7:0]  led_care;
    logic        irq;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are stable at posedge since all state moves on negedge.
  always @(posedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      cmp(mon_e.name, "GPIOf0", GPIOf0, mon_e.gpio);
      cmp(mon_e.name, "LED", {24'h0, LED & mon_e.led_care}, {24'h0, mon_e.led & mon_e.led_care});
      cmp(mon_e.name, "irq", {31'h0, irq}, {31'h0, mon_e.irq});
      cmp(mon_e.name, "PData_out", bus.PData_out, mon_e.rd);
    end
  end

  // Passes no falling edge when called right after write/tick.
  task automatic chk(input string nm, input logic [1:0] a, input logic [31:0] g,
                     input logic [7:0] l, input logic [7:0] care, input logic i,
                     input logic [31:0] r);
    exp_t e;
    e.name = nm; e.gpio = g; e.led = l; e.led_care = care; e.irq = i; e.rd = r;
    bus.addr = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Each of these passes exactly one falling edge.
  task automatic write(input logic [1:0] a, input logic [31:0] d);
    bus.EN       = 1'b1;
    bus.addr     = a;
    bus.PData_in = d;
    @(negedge clk);
    #1;
    bus.EN       = 1'b0;
    bus.PData_in = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    gpio_in      = 8'h00;
    bus.EN       = 1'b0;
    bus.addr     = 2'd0;
    bus.PData_in = '0;

    chk("rst_out",   2'd0, 32'hA5, 8'h5A, 8'hFF, 1'b0, 32'hA5);
    chk("rst_blink", 2'd2, 32'hA5, 8'h5A, 8'hFF, 1'b0, 32'h00);
    chk("rst_edge",  2'd3, 32'hA5, 8'h5A, 8'hFF, 1'b0, 32'h00);
    write(2'd0, 32'hFFFF_FFFF);
    chk("rst_wr_ignored", 2'd0, 32'hA5, 8'h5A, 8'hFF, 1'b0, 32'hA5);

    rst = 1'b0;
    write(2'd0, 32'hF0);
    chk("wr_out", 2'd0, 32'hF0, 8'h0F, 8'hFF, 1'b0, 32'hF0);
    write(2'd1, 32'hFF);
    chk("wr_tog", 2'd1, 32'h0F, 8'hF0, 8'hFF, 1'b0, 32'h0F);

    // Rising edge on bit 2: flag after the third falling edge.
    gpio_in = 8'h04;
    tick();
    chk("edge_s1", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b0, 32'h00);
    tick();
    chk("edge_s2", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b0, 32'h00);
    tick();
    chk("edge_set", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b1, 32'h04);
    write(2'd3, 32'h04);
    chk("edge_clr", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b0, 32'h00);
    tick();
    chk("edge_oneshot", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b0, 32'h00);

    // Re-arm, set the flag, then race a new edge against its clear.
    gpio_in = 8'h00;
    repeat (3) tick();
    gpio_in = 8'h04;
    repeat (3) tick();
    chk("edge_set2", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b1, 32'h04);
    gpio_in = 8'h00;
    repeat (3) tick();
    gpio_in = 8'h04;
    tick();
    tick();
    write(2'd3, 32'h04);
    chk("w1c_vs_set", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b1, 32'h04);
    write(2'd3, 32'h01);
    chk("w1c_other", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b1, 32'h04);
    write(2'd3, 32'h04);
    chk("w1c_final", 2'd3, 32'h0F, 8'hF0, 8'hFF, 1'b0, 32'h00);

    // Phase is unknown here, so only LEDs with GPIOf0 bit 0 are compared.
    write(2'd2, 32'hFF);
    chk("mask_rd", 2'd2, 32'h0F, 8'hF0, 8'hF0, 1'b0, 32'hFF);
    gpio_in = 8'h00;
    repeat (3) tick();
    gpio_in = 8'h04;
    repeat (3) tick();
    chk("pre_rst", 2'd3, 32'h0F, 8'hF0, 8'hF0, 1'b1, 32'h04);

    // Reset raised just after a falling edge; checked before the next one.
    tick();
    rst = 1'b1;
    chk("arst_out",   2'd0, 32'hA5, 8'h5A, 8'hFF, 1'b0, 32'hA5);
    chk("arst_blink", 2'd2, 32'hA5, 8'h5A, 8'hFF, 1'b0, 32'h00);
    chk("arst_edge",  2'd3, 32'hA5, 8'h5A, 8'hFF, 1'b0, 32'h00);

    // gpio_in[2] stays high across release: one edge flagged at fall 3.
    rst = 1'b0;
    write(2'd2, 32'h01);
    write(2'd0, 32'h01);
    chk("blink_k2", 2'd0, 32'h01, 8'hFF, 8'hFF, 1'b0, 32'h01);
    for (int k = 3; k <= 18; k++) begin
      tick();
      chk($sformatf("blink_k%0d", k), 2'd3, 32'h01, ((k / 4) % 2 == 1) ? 8'hFE : 8'hFF,
          8'hFF, 1'b1, 32'h04);
    end

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
